// File: rtl/clk_pkg.sv
// Shared definitions for the reset sequencer.
//   state_t / St*  : sequencer FSM encoding (WAIT, QUAL, REL, RUN)
//   LOSS_CNT_W     : width of the lock-loss event counter
//   max_u()        : helper used to size the shared qualification/gap counter
package clk_pkg;

  localparam int unsigned LOSS_CNT_W = 8;

  typedef logic [1:0] state_t;

  localparam state_t StWait = 2'd0;
  localparam state_t StQual = 2'd1;
  localparam state_t StRel  = 2'd2;
  localparam state_t StRun  = 2'd3;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Single-bit multi-flop synchroniser with asynchronous active-high reset.
//   STAGES  : number of flops (2 or more)
//   RST_VAL : value every flop takes while rst_i is high
// Ports:
//   clk_i : destination clock
//   rst_i : asynchronous reset, active-high
//   d_i   : asynchronous input bit
//   q_o   : synchronised output (last flop)
module sync_bit #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// PLL-lock qualified, staged reset-release sequencer.
// Waits for a synchronised PLL lock to stay high for LOCK_CYCLES cycles, then releases
// NUM_OUT active-low reset domains one at a time, STAGE_GAP cycles apart, and finally
// raises ready_o. Any lock loss after release drops every domain back into reset.
// Optional lock-loss statistics counter enabled by the RST_SEQ_STAT_EN macro; without it
// loss_cnt_o is tied to 0 and stat_clr_i is ignored.
// Ports:
//   clk_i      : PLL output clock (only clock)
//   rst_i      : asynchronous active-high reset
//   lock_i     : PLL LOCKED, asynchronous to clk_i
//   stat_clr_i : synchronous clear of the loss counter
//   rst_n_o    : per-domain active-low resets, bit 0 released first
//   ready_o    : all domains released and lock stable
//   loss_cnt_o : saturating lock-loss event count
module rst_seq
  import clk_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_CYCLES = 1024,
  parameter int unsigned NUM_OUT     = 4,
  parameter int unsigned STAGE_GAP   = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  lock_i,
  input  logic                  stat_clr_i,
  output logic [NUM_OUT-1:0]    rst_n_o,
  output logic                  ready_o,
  output logic [LOSS_CNT_W-1:0] loss_cnt_o
);

  localparam int unsigned CNT_W = $clog2(max_u(LOCK_CYCLES, STAGE_GAP)) + 1;

  localparam logic [CNT_W-1:0] QualLast = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] GapLast  = CNT_W'(STAGE_GAP - 1);

  logic lock_s;

  sync_bit #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_lock_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (lock_i),
    .q_o   (lock_s)
  );

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_OUT-1:0] rst_n_q, rst_n_d;
  logic               ready_q, ready_d;
  logic               loss_evt;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rst_n_d  = rst_n_q;
    ready_d  = ready_q;
    loss_evt = 1'b0;

    case (state_q)
      StWait: begin
        rst_n_d = '0;
        ready_d = 1'b0;
        cnt_d   = '0;
        if (lock_s) begin
          state_d = StQual;
        end
      end

      StQual: begin
        if (!lock_s) begin
          state_d = StWait;
          cnt_d   = '0;
        end else if (cnt_q == QualLast) begin
          state_d = StRel;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      StRel: begin
        if (!lock_s) begin
          state_d  = StWait;
          cnt_d    = '0;
          rst_n_d  = '0;
          ready_d  = 1'b0;
          loss_evt = 1'b1;
        end else begin
          cnt_d = (cnt_q == GapLast) ? '0 : cnt_q + CNT_W'(1);
          // cnt_q == 0 marks a release slot: the first cycle after REL entry, then every
          // STAGE_GAP cycles. Once every domain is out, the next slot enters RUN.
          if (cnt_q == '0) begin
            if (&rst_n_q) begin
              state_d = StRun;
              ready_d = 1'b1;
              cnt_d   = '0;
            end else begin
              // Shift a 1 in from bit 0 so domain k can never precede domain k-1.
              rst_n_d[0] = 1'b1;
              for (int k = 1; k < int'(NUM_OUT); k++) begin
                rst_n_d[k] = rst_n_q[k-1];
              end
            end
          end
        end
      end

      StRun: begin
        if (!lock_s) begin
          state_d  = StWait;
          cnt_d    = '0;
          rst_n_d  = '0;
          ready_d  = 1'b0;
          loss_evt = 1'b1;
        end
      end

      default: begin
        state_d = StWait;
        cnt_d   = '0;
        rst_n_d = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  // Asynchronous reset forces every domain low straight away, without waiting for a clock.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StWait;
      cnt_q   <= '0;
      rst_n_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_n_q <= rst_n_d;
      ready_q <= ready_d;
    end
  end

  assign rst_n_o = rst_n_q;
  assign ready_o = ready_q;

`ifdef RST_SEQ_STAT_EN
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;

  // Clear has priority over a coincident loss event; the count sticks at all-ones.
  always_comb begin
    loss_d = loss_q;
    if (stat_clr_i) begin
      loss_d = '0;
    end else if (loss_evt && (loss_q != '1)) begin
      loss_d = loss_q + LOSS_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      loss_q <= '0;
    end else begin
      loss_q <= loss_d;
    end
  end

  assign loss_cnt_o = loss_q;
`else
  logic unused_stat;
  assign unused_stat = stat_clr_i ^ loss_evt;
  assign loss_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_rst_seq.sv
// Scoreboard bench for rst_seq (SYNC_STAGES=2, LOCK_CYCLES=8, NUM_OUT=3, STAGE_GAP=4).
// Stimulus pushes time-stamped expected outputs into a queue; a negedge monitor pops
// and compares each entry at its due cycle and also checks release ordering every cycle.
module tb_rst_seq;

`ifdef RST_SEQ_STAT_EN
  localparam bit StatEn = 1'b1;
`else
  localparam bit StatEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_i;
  logic       lock_i;
  logic       stat_clr_i;
  logic [2:0] rst_n_o;
  logic       ready_o;
  logic [7:0] loss_cnt_o;

  rst_seq #(
    .SYNC_STAGES (2),
    .LOCK_CYCLES (8),
    .NUM_OUT     (3),
    .STAGE_GAP   (4)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .lock_i     (lock_i),
    .stat_clr_i (stat_clr_i),
    .rst_n_o    (rst_n_o),
    .ready_o    (ready_o),
    .loss_cnt_o (loss_cnt_o)
  );

  always #5 clk = ~clk;

  // Number of rising edges seen so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [2:0] rn;
    logic       rdy;
    logic [7:0] loss;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [7:0] el(input int n);
    if (!StatEn) return 8'd0;
    return (n > 255) ? 8'd255 : 8'(n);
  endfunction

  task automatic check(input string nm, input logic [2:0] rn, input logic rdy,
                       input logic [7:0] l);
    n_cmp++;
    if (rst_n_o !== rn || ready_o !== rdy || loss_cnt_o !== l) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got rst_n=%b ready=%b loss=%0d, want rst_n=%b ready=%b loss=%0d",
               nm, cyc, rst_n_o, ready_o, loss_cnt_o, rn, rdy, l);
    end
  endtask

  task automatic push(input int at, input logic [2:0] rn, input logic rdy, input int nl,
                      input string nm);
    exp_t e;
    e.at   = at;
    e.rn   = rn;
    e.rdy  = rdy;
    e.loss = el(nl);
    e.nm   = nm;
    q.push_back(e);
  endtask

  // Expected release sequence when lock is first sampled high at edge b.
  task automatic push_release(input int b, input int nl, input string tag);
    push(b + 10, 3'b000, 1'b0, nl, {tag, "_r0_pre"});
    push(b + 11, 3'b001, 1'b0, nl, {tag, "_r0"});
    push(b + 14, 3'b001, 1'b0, nl, {tag, "_r1_pre"});
    push(b + 15, 3'b011, 1'b0, nl, {tag, "_r1"});
    push(b + 18, 3'b011, 1'b0, nl, {tag, "_r2_pre"});
    push(b + 19, 3'b111, 1'b0, nl, {tag, "_r2"});
    push(b + 22, 3'b111, 1'b0, nl, {tag, "_rdy_pre"});
    push(b + 23, 3'b111, 1'b1, nl, {tag, "_rdy"});
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    n_cmp++;
    if ((rst_n_o[1] && !rst_n_o[0]) || (rst_n_o[2] && !rst_n_o[1])) begin
      n_bad++;
      $display("FAIL order cyc=%0d: got rst_n=%b, want monotonic release", cyc, rst_n_o);
    end
    while (q.size() > 0 && q[0].at <= cyc) begin
      e = q.pop_front();
      if (e.at < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s: due cyc=%0d, seen cyc=%0d (missed)", e.nm, e.at, cyc);
      end else begin
        check(e.nm, e.rn, e.rdy, e.loss);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  int b, b2, b3, f, c, nloss;

  initial begin
    rst_i      = 1'b1;
    lock_i     = 1'b0;
    stat_clr_i = 1'b0;
    nloss      = 0;
    #1 check("reset_state", 3'b000, 1'b0, 8'd0);
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    c = cyc;
    push(c + 4, 3'b000, 1'b0, 0, "wait_idle");
    wait_until(c + 5);

    // Test 1: lock rises and stays high.
    b = cyc + 1;
    lock_i = 1'b1;
    push_release(b, nloss, "t1");
    wait_until(b + 26);

    // Test 3: lock falls in RUN, then returns.
    f = cyc + 1;
    lock_i = 1'b0;
    push(f + 1, 3'b111, 1'b1, nloss, "t3_hold");
    nloss++;
    push(f + 2, 3'b000, 1'b0, nloss, "t3_drop");
    wait_until(f + 5);
    b = cyc + 1;
    lock_i = 1'b1;
    push_release(b, nloss, "t3_rerel");
    wait_until(b + 26);

    // Test 2: 3-cycle lock glitch during QUAL restarts qualification.
    f = cyc + 1;
    lock_i = 1'b0;
    nloss++;
    push(f + 2, 3'b000, 1'b0, nloss, "t2_pre_drop");
    wait_until(f + 5);
    b = cyc + 1;
    lock_i = 1'b1;
    push(b + 10, 3'b000, 1'b0, nloss, "t2_no_rel10");
    wait_until(b + 4);
    lock_i = 1'b0;
    wait_until(b + 7);
    lock_i = 1'b1;
    b2 = cyc + 1;
    push(b + 11, 3'b000, 1'b0, nloss, "t2_no_rel11");
    push_release(b2, nloss, "t2");
    wait_until(b2 + 26);

    // Test 5: rst_i pulse between edges 16 and 17 of a release.
    f = cyc + 1;
    lock_i = 1'b0;
    nloss++;
    push(f + 2, 3'b000, 1'b0, nloss, "t5_pre_drop");
    wait_until(f + 5);
    b = cyc + 1;
    lock_i = 1'b1;
    push(b + 11, 3'b001, 1'b0, nloss, "t5_r0");
    push(b + 15, 3'b011, 1'b0, nloss, "t5_r1");
    push(b + 16, 3'b011, 1'b0, nloss, "t5_e16");
    wait_until(b + 16);
    #2 rst_i = 1'b1;
    #1 check("t5_async", 3'b000, 1'b0, 8'd0);
    nloss = 0;
    #1 rst_i = 1'b0;
    b3 = cyc + 1;
    push_release(b3, nloss, "t5_restart");
    wait_until(b3 + 26);

    // Test 4: 300 loss events saturate the counter.
    for (int i = 0; i < 300; i++) begin
      b = cyc + 1;
      lock_i = 1'b1;
      wait_until(b + 11);
      lock_i = 1'b0;
      f = cyc + 1;
      nloss++;
      push(f + 2, 3'b000, 1'b0, nloss, "t4_loss");
      wait_until(f + 3);
    end

    // Clear coincident with a loss event: clear wins.
    b = cyc + 1;
    lock_i = 1'b1;
    wait_until(b + 11);
    lock_i = 1'b0;
    f = cyc + 1;
    push(f + 1, 3'b001, 1'b0, nloss, "t4_sat");
    nloss = 0;
    push(f + 2, 3'b000, 1'b0, nloss, "t4_clr_win");
    push(f + 4, 3'b000, 1'b0, nloss, "t4_clr_hold");
    wait_until(f + 1);
    stat_clr_i = 1'b1;
    wait_until(f + 2);
    stat_clr_i = 1'b0;
    wait_until(f + 6);

    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rst_seq.md
RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: lock synchroniser depth; legal values are 2 and above.
REQ-002 SHALL have parameter LOCK_CYCLES, default 1024: consecutive synchronised-lock cycles required before release; legal values are 1 and above.
REQ-003 SHALL have parameter NUM_OUT, default 4: number of staged reset domains; legal values are 1 to 16.
REQ-004 SHALL have parameter STAGE_GAP, default 16: clk_i cycles between successive domain releases; legal values are 1 and above.
REQ-005 SHALL have port clk_i, input, 1 bit: PLL output clock; the only clock.
REQ-006 SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port lock_i, input, 1 bit: PLL LOCKED, asynchronous to clk_i.
REQ-008 SHALL have port stat_clr_i, input, 1 bit: synchronous clear of the loss counter.
REQ-009 SHALL have port rst_n_o, output, NUM_OUT bits: per-domain active-low resets; bit 0 is released first.
REQ-010 SHALL have port ready_o, output, 1 bit: all domains released and lock stable.
REQ-011 SHALL have port loss_cnt_o, output, 8 bits: saturating count of lock-loss events.

Function
REQ-012 SHALL pass lock_i through SYNC_STAGES flops (reset value 0); the synchronised result is lock_s.
REQ-013 SHALL implement a state machine with states WAIT, QUAL, REL and RUN; all outputs SHALL be registered.
REQ-014 WAIT: rst_n_o SHALL be all 0 and ready_o 0; lock_s=1 SHALL move the FSM to QUAL with the counter at 0.
REQ-015 QUAL: counter SHALL increment each cycle that lock_s=1; lock_s=0 SHALL return the FSM to WAIT with the counter at 0; reaching counter LOCK_CYCLES-1 with lock_s=1 SHALL move the FSM to REL.
REQ-016 REL: rst_n_o[0] SHALL rise on REL entry; rst_n_o[k] SHALL rise STAGE_GAP cycles after rst_n_o[k-1]; STAGE_GAP cycles after rst_n_o[NUM_OUT-1] rises, the FSM SHALL enter RUN and ready_o SHALL rise.
REQ-017 Latency: rst_n_o[0] SHALL rise on clk_i edge SYNC_STAGES+LOCK_CYCLES+1, counted from the edge that first samples lock_i=1 (edge 0), given lock_i stays high.
REQ-018 lock_s=0 in REL or RUN SHALL, on the next edge, drive rst_n_o to all 0 and ready_o to 0, set the state to WAIT and count one loss event.
REQ-019 Total response from lock_i falling to reset assertion SHALL be SYNC_STAGES+1 edges.
REQ-020 Release order SHALL be strictly monotonic: rst_n_o[k] is never 1 while rst_n_o[k-1] is 0.
REQ-021 loss_cnt_o SHALL saturate at 255.
REQ-022 stat_clr_i=1 SHALL zero loss_cnt_o on the next edge; if clear and a loss event fall on the same edge, the clear SHALL win and the result is 0.
REQ-023 Counter width SHALL be $clog2 of max(LOCK_CYCLES, STAGE_GAP) plus 1, with no wrap-around.

Reset
REQ-024 rst_i assertion SHALL immediately force, independent of clk_i: rst_n_o to all 0, ready_o to 0, state to WAIT, synchroniser and counters to 0, and loss_cnt_o to 0.
REQ-025 rst_i asserted mid-REL SHALL re-assert already released domains immediately, with no glitch to 1 on any bit.
REQ-026 After rst_i deasserts, the block SHALL always restart full qualification from WAIT, even if lock_i is already high.

Configuration
REQ-027 Macro RST_SEQ_STAT_EN defined: the loss counter and stat_clr_i SHALL be implemented as specified in REQ-018, REQ-021 and REQ-022.
REQ-028 Macro RST_SEQ_STAT_EN undefined: loss_cnt_o SHALL be constant 0, stat_clr_i SHALL be ignored, and no counter flops SHALL be present; all other behaviour is unchanged.

Structure
REQ-029 The FSM state enum (WAIT, QUAL, REL, RUN) and the loss-counter width constant LOSS_CNT_W=8 SHALL live in the shared package clk_pkg.
REQ-030 The lock synchroniser SHALL be a separate sub-module, sync_bit, parameterised by stage count and reset value; rst_seq instantiates it once.

Verification (SYNC_STAGES=2, LOCK_CYCLES=8, NUM_OUT=3, STAGE_GAP=4)
REQ-031 Test 1 (lock_i rises at edge 0 and stays high) SHALL show: rst_n_o[0] high at edge 11, rst_n_o[1] at edge 15, rst_n_o[2] at edge 19, ready_o at edge 23, loss_cnt_o=0.
REQ-032 Test 2 (lock_i low for 3 cycles in the middle of QUAL) SHALL show: qualification restarts; rst_n_o[0] rises 11 edges after lock_i returns high.
REQ-033 Test 3 (lock_i falls in RUN) SHALL show: rst_n_o=000 and ready_o=0 at the 3rd edge; loss_cnt_o=1; re-release follows the Test 1 timing after lock returns.
REQ-034 Test 4 (300 loss events) SHALL show: loss_cnt_o=255; then stat_clr_i coincident with a loss event SHALL give loss_cnt_o=0.
REQ-035 Test 5 (rst_i pulsed between edges 16 and 17, during REL) SHALL show: rst_n_o=000 within the same delta, loss_cnt_o=0, and a full restart with rst_n_o[0] rising 11 edges after rst_i falls.
REQ-036 Test 6 (build without RST_SEQ_STAT_EN, repeat Test 3) SHALL show: loss_cnt_o stays 0; all other timing identical to Test 3.
